xtea_out_serializer: RTL
========================

# xtea_out_serializer

Downstream stage of the `xtea` core. It captures each 128-bit result block that the core presents on `data_out` with its `ready` pulse. Captured blocks are buffered in a small FIFO and streamed to the system bus as four 32-bit words under a valid/ready handshake. `busy` is exported so the controller upstream of `xtea` holds off `start` while the buffer cannot accept another result.

## Interface
- `DEPTH`, default 2: block FIFO depth in 128-bit entries; legal values 2 or 4.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `blk_in` input 128: result block, connected to `xtea.data_out`.
- `blk_valid` input 1: connected to `xtea.ready`; high for one cycle per completed block, with `blk_in` valid in that cycle.
- `busy` output 1: FIFO full; upstream must not issue `start`.
- `word_out` output 32: current output word.
- `word_valid` output 1: `word_out` is valid.
- `word_ready` input 1: downstream accepts `word_out`.
- `word_last` output 1: the current word is the 4th word of its block.
- `overflow` output 1: sticky; set when a block was dropped.

## Operation
- **Storage:** DEPTH x 128 circular FIFO with write pointer, read pointer and occupancy count (0..DEPTH). There is also a 2-bit word index `idx` into the head block.
- **Push:** occurs on `blk_valid` when count < DEPTH, or when count == DEPTH and a block pop happens in the same cycle.
- **Dropped blocks:** `blk_valid` with count == DEPTH and no pop in that cycle drops the block. `overflow` is set and FIFO contents are unchanged.
- **Word transfer:** `word_valid & word_ready` in a cycle. Each transfer increments `idx` (wraps 3 -> 0).
- **Block pop:** the transfer at `idx` == 3 pops the head block and advances the read pointer.
- **State machine:**
  - IDLE (count == 0, `word_valid` = 0) goes to SEND on a push.
  - SEND (`word_valid` = 1) stays in SEND while count > 0 after the pop/push update.
  - SEND returns to IDLE when count becomes 0.
- **Outputs:**
  - `word_out` = the selected 32-bit slice of the head entry (see Configuration), or 0 in IDLE.
  - `word_last` = `word_valid & (idx == 3)`.
  - `busy` = (count == DEPTH).
- **Holding `word_out`:** when `word_ready` is low, `word_out`, `word_valid` and `word_last` hold their values.
- **Reset:** clears pointers, count, `idx`, `overflow` and the state. The outputs read `busy` = 0, `word_out` = 0, `word_valid` = 0, `word_last` = 0, `overflow` = 0. A block being streamed when reset asserts is discarded, and no partial words follow.

## Timing
- **Latency:** a block pushed at edge N into an empty FIFO gives `word_valid` = 1 with word 0 from edge N (visible in cycle N+1).
- **Throughput:** with `word_ready` held high, one word is output per cycle. There is no bubble between consecutive buffered blocks; word 0 of the next block follows word 3 of the previous block directly.
- **Simultaneous events:**
  - Push and pop in the same cycle leave count unchanged.
  - A push into an empty FIFO in the same cycle as an unrelated transfer is not possible, because IDLE has no transfer.
- **`busy` timing:** `busy` is derived from registered count. It rises the cycle after the push that fills the FIFO and falls the cycle after the pop.
- **`overflow`:** asserts the cycle after the dropping `blk_valid`. Only `reset` clears it.

## Configuration
- Macro `XTEA_SER_MSW_FIRST_EN`.
- **Defined:** word order is `blk_in[127:96]`, `[95:64]`, `[63:32]`, `[31:0]` (idx 0..3).
- **Undefined:** word order is `[31:0]`, `[63:32]`, `[95:64]`, `[127:96]`.
- No other behaviour changes.

## Test plan
- **Single block:** after reset, push `128'h5A5A5A5AFEDCBA9801234567A5A5A5A5` with `word_ready` = 1.
  - With the macro defined: words 5A5A5A5A, FEDCBA98, 01234567, A5A5A5A5 on consecutive cycles, `word_last` only on the 4th, then `word_valid` = 0.
  - With the macro undefined: the order is reversed.
- **Backpressure:** push one block with `word_ready` = 0 for 5 cycles, then 1. `word_out` holds word 0 throughout the stall, then 4 words follow with no loss or duplication.
- **Full / overflow (DEPTH = 2, `word_ready` = 0):**
  - Push A and B: `busy` = 1 after B.
  - Push C: C is dropped, `overflow` = 1 next cycle.
  - Release `word_ready`: only the 8 words of A and B appear, and `overflow` stays 1.
- **Push on pop:** with the FIFO full, `blk_valid` arrives in the same cycle as the 4th-word transfer. The block is accepted, `overflow` stays 0, and 12 words are output in total without gaps.
- **Reset mid-stream:** assert `reset` after word 1 of a block. All outputs are 0 in the same cycle. After release, a new block streams from its word 0 and `overflow` = 0.

Source files
------------

// File: rtl/xtea_out_serializer.sv
// xtea_out_serializer: buffers xtea result blocks and streams them as 32-bit words; XTEA_SER_MSW_FIRST_EN selects MSW-first word order.
module xtea_out_serializer #(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] blk_in,
  input  logic         blk_valid,
  output logic         busy,
  output logic [31:0]  word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         word_last,
  output logic         overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [127:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] idx, sel;
  logic pop, push, xfer;
  logic [127:0] head;
  always_comb begin
    word_valid = state == SEND;
    xfer = word_valid & word_ready;
    pop = xfer & (idx == 2'd3);
    push = blk_valid & ((cnt != FULL) | pop);
    cnt_n = cnt + CW'(push) - CW'(pop);
    state_n = (cnt_n != '0) ? SEND : IDLE;
    head = mem[rp];
`ifdef XTEA_SER_MSW_FIRST_EN
    sel = ~idx;
`else
    sel = idx;
`endif
    word_out = word_valid ? head[{sel, 5'b0} +: 32] : '0;
    word_last = word_valid & (idx == 2'd3);
    busy = cnt == FULL;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      idx <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (xfer) idx <= idx + 1'b1;
      overflow <= overflow | (blk_valid & ~push);
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= blk_in;
  end
endmodule
